// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared ALU operation codes, funct/op-class encodings and ID-stage ALU decode
package mips_pkg;

    localparam logic [2:0] ALU_AND = 3'd0;
    localparam logic [2:0] ALU_OR  = 3'd1;
    localparam logic [2:0] ALU_ADD = 3'd2;
    localparam logic [2:0] ALU_SUB = 3'd3;
    localparam logic [2:0] ALU_SLT = 3'd7;

    localparam logic [5:0] FUNCT_ADD = 6'h20;
    localparam logic [5:0] FUNCT_SUB = 6'h22;
    localparam logic [5:0] FUNCT_AND = 6'h24;
    localparam logic [5:0] FUNCT_OR  = 6'h25;
    localparam logic [5:0] FUNCT_SLT = 6'h2A;

    localparam logic [1:0] OPC_ADD   = 2'b00;
    localparam logic [1:0] OPC_SUB   = 2'b01;
    localparam logic [1:0] OPC_RTYPE = 2'b10;
    localparam logic [1:0] OPC_RSVD  = 2'b11;

    typedef enum logic [1:0] {
        FWD_NONE  = 2'd0,
        FWD_EXMEM = 2'd1,
        FWD_MEMWB = 2'd2
    } fwd_sel_e;

    // Returns {illegal, alu_operation}; the reserved class executes as an add.
    function automatic logic [3:0] alu_decode(input logic [1:0] op_class, input logic [5:0] funct);
        logic [3:0] r;
        r = {1'b0, ALU_ADD};
        case (op_class)
            OPC_SUB: r = {1'b0, ALU_SUB};
            OPC_RTYPE: begin
                case (funct)
                    FUNCT_ADD: r = {1'b0, ALU_ADD};
                    FUNCT_SUB: r = {1'b0, ALU_SUB};
                    FUNCT_AND: r = {1'b0, ALU_AND};
                    FUNCT_OR:  r = {1'b0, ALU_OR};
                    FUNCT_SLT: r = {1'b0, ALU_SLT};
                    default:   r = {1'b1, ALU_ADD};
                endcase
            end
            default: r = {1'b0, ALU_ADD};
        endcase
        return r;
    endfunction

endpackage

// File: rtl/forward_unit.sv
// rtl/forward_unit.sv - selects the forwarding source for one EX operand
module forward_unit
    import mips_pkg::*;
#(
    parameter int REG_AW = 5
) (
    input  logic [REG_AW-1:0] src_i,
    input  logic              exmem_reg_write_i,
    input  logic [REG_AW-1:0] exmem_rd_i,
    input  logic              memwb_reg_write_i,
    input  logic [REG_AW-1:0] memwb_rd_i,
    output fwd_sel_e          sel_o
);

    // The younger EX/MEM result shadows MEM/WB; register 0 is hardwired and never forwarded.
    always_comb begin
        sel_o = FWD_NONE;
        if (src_i != '0) begin
            if (exmem_reg_write_i && (exmem_rd_i == src_i)) begin
                sel_o = FWD_EXMEM;
            end else if (memwb_reg_write_i && (memwb_rd_i == src_i)) begin
                sel_o = FWD_MEMWB;
            end
        end
    end

endmodule

// File: rtl/id_ex_operand_stage.sv
// rtl/id_ex_operand_stage.sv - ID/EX register, ALU decode, forwarding and hazard stall; IDEX_FORWARDING_EN enables bypassing
module id_ex_operand_stage
    import mips_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              id_valid,
    input  logic [DATA_W-1:0] id_rs_data,
    input  logic [DATA_W-1:0] id_rt_data,
    input  logic [DATA_W-1:0] id_imm,
    input  logic [REG_AW-1:0] id_rs,
    input  logic [REG_AW-1:0] id_rt,
    input  logic [REG_AW-1:0] id_rd,
    input  logic              id_alu_src,
    input  logic [1:0]        id_op_class,
    input  logic [5:0]        id_funct,
    input  logic              id_reg_write,
    input  logic              id_mem_read,
    input  logic              id_mem_write,
    input  logic              flush,
    input  logic              exmem_reg_write,
    input  logic [REG_AW-1:0] exmem_rd,
    input  logic [DATA_W-1:0] exmem_result,
    input  logic              memwb_reg_write,
    input  logic [REG_AW-1:0] memwb_rd,
    input  logic [DATA_W-1:0] memwb_result,
    output logic              stall_id,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic [2:0]        alu_operation,
    output logic [DATA_W-1:0] ex_store_data,
    output logic              ex_valid,
    output logic              ex_reg_write,
    output logic              ex_mem_read,
    output logic              ex_mem_write,
    output logic [REG_AW-1:0] ex_rd,
    output logic              ex_illegal
);

`ifdef IDEX_FORWARDING_EN
    localparam logic FWD_EN = 1'b1;
`else
    localparam logic FWD_EN = 1'b0;
`endif

    logic              valid_q, valid_d;
    logic              reg_write_q, reg_write_d;
    logic              mem_read_q, mem_read_d;
    logic              mem_write_q, mem_write_d;
    logic              illegal_q, illegal_d;
    logic              alu_src_q, alu_src_d;
    logic [2:0]        alu_op_q, alu_op_d;
    logic [REG_AW-1:0] rd_q, rd_d;
    logic [REG_AW-1:0] rs_q, rs_d;
    logic [REG_AW-1:0] rt_q, rt_d;
    logic [DATA_W-1:0] rs_data_q, rs_data_d;
    logic [DATA_W-1:0] rt_data_q, rt_data_d;
    logic [DATA_W-1:0] imm_q, imm_d;

    logic [3:0]        dec;
    logic              rt_read;
    logic              hazard;
    logic              bubble;
    fwd_sel_e          sel_rs, sel_rt;
    logic [DATA_W-1:0] fwd_rs, fwd_rt;

    assign dec     = alu_decode(id_op_class, id_funct);
    assign rt_read = ~id_alu_src | id_mem_write;

`ifdef IDEX_FORWARDING_EN
    assign hazard = id_valid & valid_q & mem_read_q & (rd_q != '0) &
                    ((rd_q == id_rs) | (rt_read & (rd_q == id_rt)));
`else
    // Without bypassing, any producer still ahead of the register-file write must be waited out.
    assign hazard = id_valid & (
                    (valid_q & reg_write_q & (rd_q != '0) &
                     ((rd_q == id_rs) | (rt_read & (rd_q == id_rt)))) |
                    (exmem_reg_write & (exmem_rd != '0) &
                     ((exmem_rd == id_rs) | (rt_read & (exmem_rd == id_rt)))));
`endif

    assign stall_id = rst_n & hazard;
    assign bubble   = flush | stall_id;

    always_comb begin
        valid_d     = id_valid;
        reg_write_d = id_reg_write;
        mem_read_d  = id_mem_read;
        mem_write_d = id_mem_write;
        illegal_d   = dec[3];
        alu_src_d   = id_alu_src;
        alu_op_d    = dec[2:0];
        rd_d        = id_rd;
        rs_d        = id_rs;
        rt_d        = id_rt;
        rs_data_d   = id_rs_data;
        rt_data_d   = id_rt_data;
        imm_d       = id_imm;
        if (bubble) begin
            valid_d     = 1'b0;
            reg_write_d = 1'b0;
            mem_read_d  = 1'b0;
            mem_write_d = 1'b0;
            illegal_d   = 1'b0;
            alu_src_d   = 1'b0;
            alu_op_d    = '0;
            rd_d        = '0;
            rs_d        = '0;
            rt_d        = '0;
            rs_data_d   = '0;
            rt_data_d   = '0;
            imm_d       = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q     <= 1'b0;
            reg_write_q <= 1'b0;
            mem_read_q  <= 1'b0;
            mem_write_q <= 1'b0;
            illegal_q   <= 1'b0;
            alu_src_q   <= 1'b0;
            alu_op_q    <= '0;
            rd_q        <= '0;
            rs_q        <= '0;
            rt_q        <= '0;
            rs_data_q   <= '0;
            rt_data_q   <= '0;
            imm_q       <= '0;
        end else begin
            valid_q     <= valid_d;
            reg_write_q <= reg_write_d;
            mem_read_q  <= mem_read_d;
            mem_write_q <= mem_write_d;
            illegal_q   <= illegal_d;
            alu_src_q   <= alu_src_d;
            alu_op_q    <= alu_op_d;
            rd_q        <= rd_d;
            rs_q        <= rs_d;
            rt_q        <= rt_d;
            rs_data_q   <= rs_data_d;
            rt_data_q   <= rt_data_d;
            imm_q       <= imm_d;
        end
    end

    // With bypassing disabled the write enables are masked, so both selects stay at FWD_NONE.
    forward_unit #(.REG_AW(REG_AW)) u_fwd_rs (
        .src_i             (rs_q),
        .exmem_reg_write_i (exmem_reg_write & FWD_EN),
        .exmem_rd_i        (exmem_rd),
        .memwb_reg_write_i (memwb_reg_write & FWD_EN),
        .memwb_rd_i        (memwb_rd),
        .sel_o             (sel_rs)
    );

    forward_unit #(.REG_AW(REG_AW)) u_fwd_rt (
        .src_i             (rt_q),
        .exmem_reg_write_i (exmem_reg_write & FWD_EN),
        .exmem_rd_i        (exmem_rd),
        .memwb_reg_write_i (memwb_reg_write & FWD_EN),
        .memwb_rd_i        (memwb_rd),
        .sel_o             (sel_rt)
    );

    always_comb begin
        fwd_rs = rs_data_q;
        case (sel_rs)
            FWD_EXMEM: fwd_rs = exmem_result;
            FWD_MEMWB: fwd_rs = memwb_result;
            default:   fwd_rs = rs_data_q;
        endcase
    end

    always_comb begin
        fwd_rt = rt_data_q;
        case (sel_rt)
            FWD_EXMEM: fwd_rt = exmem_result;
            FWD_MEMWB: fwd_rt = memwb_result;
            default:   fwd_rt = rt_data_q;
        endcase
    end

    assign alu_a         = fwd_rs;
    assign alu_b         = alu_src_q ? imm_q : fwd_rt;
    assign ex_store_data = fwd_rt;
    assign alu_operation = alu_op_q;
    assign ex_valid      = valid_q;
    assign ex_reg_write  = reg_write_q;
    assign ex_mem_read   = mem_read_q;
    assign ex_mem_write  = mem_write_q;
    assign ex_rd         = rd_q;
    assign ex_illegal    = illegal_q;

endmodule

// File: tb/tb_id_ex_operand_stage.sv
// tb/tb_id_ex_operand_stage.sv - directed scoreboard bench for id_ex_operand_stage (both IDEX_FORWARDING_EN builds)
module tb_id_ex_operand_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        id_valid;
    logic [31:0] id_rs_data, id_rt_data, id_imm;
    logic [4:0]  id_rs, id_rt, id_rd;
    logic        id_alu_src;
    logic [1:0]  id_op_class;
    logic [5:0]  id_funct;
    logic        id_reg_write, id_mem_read, id_mem_write;
    logic        flush;
    logic        exmem_reg_write;
    logic [4:0]  exmem_rd;
    logic [31:0] exmem_result;
    logic        memwb_reg_write;
    logic [4:0]  memwb_rd;
    logic [31:0] memwb_result;
    logic        stall_id;
    logic [31:0] alu_a, alu_b, ex_store_data;
    logic [2:0]  alu_operation;
    logic        ex_valid, ex_reg_write, ex_mem_read, ex_mem_write, ex_illegal;
    logic [4:0]  ex_rd;

    id_ex_operand_stage #(.DATA_W(32), .REG_AW(5)) dut (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid),
        .id_rs_data(id_rs_data), .id_rt_data(id_rt_data), .id_imm(id_imm),
        .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
        .id_alu_src(id_alu_src), .id_op_class(id_op_class), .id_funct(id_funct),
        .id_reg_write(id_reg_write), .id_mem_read(id_mem_read), .id_mem_write(id_mem_write),
        .flush(flush),
        .exmem_reg_write(exmem_reg_write), .exmem_rd(exmem_rd), .exmem_result(exmem_result),
        .memwb_reg_write(memwb_reg_write), .memwb_rd(memwb_rd), .memwb_result(memwb_result),
        .stall_id(stall_id), .alu_a(alu_a), .alu_b(alu_b), .alu_operation(alu_operation),
        .ex_store_data(ex_store_data), .ex_valid(ex_valid), .ex_reg_write(ex_reg_write),
        .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write), .ex_rd(ex_rd),
        .ex_illegal(ex_illegal)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        v, rw, mr, mw, ill;
        logic [4:0]  rd;
        logic [2:0]  op;
        logic [31:0] a, b, sd;
    } exp_t;

    exp_t sb[$];
    int   n_assert = 0;
    int   n_fail   = 0;
    logic       m_v, m_rw, m_mr;
    logic [4:0] m_rd;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [3:0] dec_model(input logic [1:0] c, input logic [5:0] f);
        if (c == 2'b01) return 4'h3;
        if (c != 2'b10) return 4'h2;
        case (f)
            6'h20: return 4'h2;
            6'h22: return 4'h3;
            6'h24: return 4'h0;
            6'h25: return 4'h1;
            6'h2A: return 4'h7;
            default: return 4'hA;
        endcase
    endfunction

    function automatic logic [31:0] fwd_model(input logic [4:0] src, input logic [31:0] rf);
`ifdef IDEX_FORWARDING_EN
        if (src != 0 && exmem_reg_write && exmem_rd == src) return exmem_result;
        if (src != 0 && memwb_reg_write && memwb_rd == src) return memwb_result;
`endif
        return rf;
    endfunction

    function automatic logic raw(input logic en, input logic [4:0] rd);
        logic rt_rd;
        rt_rd = !id_alu_src || id_mem_write;
        return en && rd != 0 && (rd == id_rs || (rt_rd && rd == id_rt));
    endfunction

    function automatic logic stall_model();
`ifdef IDEX_FORWARDING_EN
        return id_valid && raw(m_v && m_mr, m_rd);
`else
        return id_valid && (raw(m_v && m_rw, m_rd) || raw(exmem_reg_write, exmem_rd));
`endif
    endfunction

    task automatic set_id(input logic v, input logic [1:0] c, input logic [5:0] f,
                          input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                          input logic [31:0] rsd, input logic [31:0] rtd, input logic [31:0] imm,
                          input logic asrc, input logic rw, input logic mr, input logic mw);
        id_valid = v; id_op_class = c; id_funct = f;
        id_rs = rs; id_rt = rt; id_rd = rd;
        id_rs_data = rsd; id_rt_data = rtd; id_imm = imm;
        id_alu_src = asrc; id_reg_write = rw; id_mem_read = mr; id_mem_write = mw;
    endtask

    task automatic step(input string tag);
        exp_t       e;
        logic       st;
        logic [3:0] d;
        logic [31:0] rsf, rtf;
        #1;
        st = stall_model();
        chk({tag, ".stall"}, 32'(stall_id), 32'(st));
        e = '0;
        if (!(flush || st)) begin
            d   = dec_model(id_op_class, id_funct);
            rsf = fwd_model(id_rs, id_rs_data);
            rtf = fwd_model(id_rt, id_rt_data);
            e.v = id_valid; e.rw = id_reg_write; e.mr = id_mem_read; e.mw = id_mem_write;
            e.ill = d[3]; e.op = d[2:0]; e.rd = id_rd;
            e.a = rsf; e.b = id_alu_src ? id_imm : rtf; e.sd = rtf;
        end
        sb.push_back(e);
        @(posedge clk);
        #1;
        e = sb.pop_front();
        chk({tag, ".ctrl"}, 32'({ex_valid, ex_reg_write, ex_mem_read, ex_mem_write, ex_illegal}),
            32'({e.v, e.rw, e.mr, e.mw, e.ill}));
        chk({tag, ".rd"}, 32'(ex_rd), 32'(e.rd));
        chk({tag, ".op"}, 32'(alu_operation), 32'(e.op));
        chk({tag, ".alu_a"}, alu_a, e.a);
        chk({tag, ".alu_b"}, alu_b, e.b);
        chk({tag, ".store"}, ex_store_data, e.sd);
        m_v = e.v; m_rw = e.rw; m_mr = e.mr; m_rd = e.rd;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, ".ctrl"}, 32'({stall_id, ex_valid, ex_reg_write, ex_mem_read, ex_mem_write,
                                 ex_illegal, alu_operation, ex_rd}), 32'h0);
        chk({tag, ".data"}, alu_a | alu_b | ex_store_data, 32'h0);
    endtask

    initial begin
        logic [5:0] functs[6];
        functs = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A, 6'h27};
        m_v = 0; m_rw = 0; m_mr = 0; m_rd = 0;
        rst_n = 1'b0; flush = 1'b0;
        exmem_reg_write = 0; exmem_rd = 0; exmem_result = 0;
        memwb_reg_write = 0; memwb_rd = 0; memwb_result = 0;
        set_id(1, 2'b10, 6'h20, 5'd1, 5'd2, 5'd3, 32'd5, 32'd7, 32'd0, 0, 1, 0, 0);
        repeat (2) @(posedge clk);
        #1;
        chk_all_zero("reset");
        rst_n = 1'b1;

        // R-type add, no hazards
        step("add");

        // EX/MEM and MEM/WB both target r8
        exmem_reg_write = 1; exmem_rd = 5'd8; exmem_result = 32'h100;
        memwb_reg_write = 1; memwb_rd = 5'd8; memwb_result = 32'h200;
        set_id(1, 2'b10, 6'h20, 5'd8, 5'd2, 5'd4, 32'h55, 32'h66, 32'd0, 0, 1, 0, 0);
        step("b2b");
        exmem_reg_write = 0; memwb_reg_write = 0;
        set_id(1, 2'b10, 6'h20, 5'd8, 5'd2, 5'd4, 32'h55, 32'h66, 32'd0, 0, 1, 0, 0);
        step("b2b_reissue");

        // Load-use on r9
        set_id(1, 2'b00, 6'h00, 5'd1, 5'd9, 5'd9, 32'h1000, 32'h0, 32'h10, 1, 1, 1, 0);
        step("lw9");
        set_id(1, 2'b10, 6'h22, 5'd9, 5'd2, 5'd5, 32'hAA, 32'h3, 32'd0, 0, 1, 0, 0);
        step("lu_stall");
        memwb_reg_write = 1; memwb_rd = 5'd9; memwb_result = 32'h300;
        step("lu_issue");
        memwb_reg_write = 0;

        // Flush coinciding with a load-use stall
        set_id(1, 2'b00, 6'h00, 5'd1, 5'd10, 5'd10, 32'h2000, 32'h0, 32'h20, 1, 1, 1, 0);
        step("lw10");
        set_id(1, 2'b10, 6'h20, 5'd10, 5'd2, 5'd6, 32'h1, 32'h2, 32'd0, 0, 1, 0, 0);
        flush = 1'b1;
        step("flush_stall");
        flush = 1'b0;

        // Funct sweep including unsupported 0x27, then the other op classes
        foreach (functs[i]) begin
            set_id(1, 2'b10, functs[i], 5'd1, 5'd2, 5'd3, 32'h11 + i, 32'h22 + i, 32'd0, 0, 1, 0, 0);
            step($sformatf("funct%0h", functs[i]));
        end
        for (int c = 0; c < 4; c++) begin
            set_id(1, 2'(c), 6'h3F, 5'd11, 5'd12, 5'd13, 32'h40, 32'h50, 32'h60, c == 0, 1, 0, 0);
            step($sformatf("class%0d", c));
        end

        // Store: B takes the immediate, rt goes to store data
        set_id(1, 2'b00, 6'h00, 5'd14, 5'd15, 5'd0, 32'h700, 32'hBEEF, 32'h8, 1, 0, 0, 1);
        step("store");

        // Register 0 is never forwarded
        exmem_reg_write = 1; exmem_rd = 5'd0; exmem_result = 32'hDEAD;
        set_id(1, 2'b10, 6'h25, 5'd0, 5'd16, 5'd17, 32'h1234, 32'h0F, 32'd0, 0, 1, 0, 0);
        step("r0");
        exmem_reg_write = 0;

        // Reset while a load-use stall is pending
        set_id(1, 2'b00, 6'h00, 5'd1, 5'd18, 5'd18, 32'h3000, 32'h0, 32'h4, 1, 1, 1, 0);
        step("lw18");
        set_id(1, 2'b10, 6'h20, 5'd18, 5'd2, 5'd7, 32'h9, 32'h9, 32'd0, 0, 1, 0, 0);
        #1;
        chk("pre_reset.stall", 32'(stall_id), 32'(stall_model()));
        rst_n = 1'b0;
        #1;
        chk_all_zero("mid_reset");
        m_v = 0; m_rw = 0; m_mr = 0; m_rd = 0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        step("post_reset");

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
